// File: rtl/lag_pkg.sv
// lag_pkg: shared lag types, FSM states and the 36-bit lagsin conduit layout
package lag_pkg;
  localparam int LAG_W = 12;
  typedef struct packed {
    logic [LAG_W-1:0] bc;
    logic [LAG_W-1:0] ac;
    logic [LAG_W-1:0] ab;
  } lag_triple_t;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} lag_state_t;
  function automatic logic [3*LAG_W-1:0] pack_lags(lag_triple_t t);
    return {t.bc, t.ac, t.ab};
  endfunction
  function automatic lag_triple_t unpack_lags(logic [3*LAG_W-1:0] w);
    return '{bc: w[3*LAG_W-1:2*LAG_W], ac: w[2*LAG_W-1:LAG_W], ab: w[LAG_W-1:0]};
  endfunction
endpackage

// File: rtl/lag_accum_lane.sv
// lag_accum_lane: one signed accumulator with load, add, clear and floor-shifted average
module lag_accum_lane #(
  parameter int LAG_W    = 12,
  parameter int LOG2_AVG = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             add,
  input  logic             clr,
  input  logic [LAG_W-1:0] din,
  output logic [LAG_W-1:0] avg
);
  localparam int AW = LAG_W + LOG2_AVG;
  logic signed [AW-1:0] acc_q, acc_d, ext, sum;
  // avg reflects the sum including din, so the final add's average is ready the same cycle
  always_comb begin
    ext = {{LOG2_AVG{din[LAG_W-1]}}, din};
    sum = acc_q + ext;
    acc_d = clr ? '0 : load ? ext : add ? sum : acc_q;
    avg = LAG_W'(sum >>> LOG2_AVG);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/lag_averager.sv
// lag_averager: averages 2^LOG2_AVG lag triples for the lag peripheral.
// Define LAG_AVG_OUTLIER_REJECT_EN to reject triples with any |lag| > MAX_LAG.
module lag_averager
  import lag_pkg::*;
#(
  parameter int LOG2_AVG    = 2,
  parameter int MAX_LAG     = 40,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               lag_in_valid,
  input  logic [LAG_W-1:0]   lag_in_ab,
  input  logic [LAG_W-1:0]   lag_in_ac,
  input  logic [LAG_W-1:0]   lag_in_bc,
  output logic [3*LAG_W-1:0] lagsout,
  output logic               lagsout_valid,
  output logic               timeout_pulse,
  output logic [7:0]         drop_count
);
  localparam int N  = 1 << LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  if (LOG2_AVG < 1 || LOG2_AVG > 6 || MAX_LAG < 1) begin : g_bad_params
    $error("lag_averager: illegal LOG2_AVG or MAX_LAG");
  end
  lag_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3*LAG_W-1:0] lags_q, lags_d;
  logic valid_q, valid_d, tmo_q, tmo_d, ok, acc, load, add, clr;
  logic [LAG_W-1:0] din [3];
  logic [LAG_W-1:0] avg [3];
  assign din = '{lag_in_ab, lag_in_ac, lag_in_bc};
  for (genvar i = 0; i < 3; i++) begin : g_lane
    lag_accum_lane #(.LAG_W(LAG_W), .LOG2_AVG(LOG2_AVG)) u_lane (
      .clk(clk), .reset_n(reset_n), .load(load), .add(add), .clr(clr),
      .din(din[i]), .avg(avg[i])
    );
  end
`ifdef LAG_AVG_OUTLIER_REJECT_EN
  localparam logic signed [LAG_W-1:0] LIM = LAG_W'(MAX_LAG);
  logic [7:0] drop_q, drop_d;
  always_comb begin
    ok = 1'b1;
    for (int k = 0; k < 3; k++) ok = ok && $signed(din[k]) <= LIM && $signed(din[k]) >= -LIM;
    drop_d = (lag_in_valid && !clear && !ok && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_q <= '0;
    else drop_q <= drop_d;
  assign drop_count = drop_q;
`else
  assign ok = 1'b1;
  assign drop_count = '0;
`endif
  assign acc = lag_in_valid && !clear && ok;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idle_d = idle_q;
    lags_d = lags_q;
    valid_d = 1'b0;
    tmo_d = 1'b0;
    load = 1'b0;
    add = 1'b0;
    clr = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d = '0;
      idle_d = '0;
      clr = 1'b1;
    end else if (state_q != ACCUM) begin
      load = acc;
      cnt_d = acc ? CW'(1) : '0;
      state_d = acc ? ACCUM : IDLE;
    end else if (acc) begin
      idle_d = '0;
      if (cnt_q == CW'(N - 1)) begin
        lags_d = pack_lags('{bc: avg[2], ac: avg[1], ab: avg[0]});
        valid_d = 1'b1;
        clr = 1'b1;
        cnt_d = '0;
        state_d = EMIT;
      end else begin
        add = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (idle_q == IW'(TIMEOUT_CYC)) begin
      state_d = IDLE;
      cnt_d = '0;
      idle_d = '0;
      clr = 1'b1;
      tmo_d = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idle_q <= '0;
      lags_q <= '0;
      valid_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idle_q <= idle_d;
      lags_q <= lags_d;
      valid_q <= valid_d;
      tmo_q <= tmo_d;
    end
  assign lagsout = lags_q;
  assign lagsout_valid = valid_q;
  assign timeout_pulse = tmo_q;
endmodule

// File: tb/tb_lag_averager.sv
// tb_lag_averager: directed vectors against a queue-based window model plus literal checkpoints
module tb_lag_averager;
  localparam int N = 4;
  localparam int T = 20;
  localparam int MAXL = 40;
`ifdef LAG_AVG_OUTLIER_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic lag_in_valid = 1'b0;
  logic [11:0] lag_in_ab = '0, lag_in_ac = '0, lag_in_bc = '0;
  logic [35:0] lagsout;
  logic lagsout_valid, timeout_pulse;
  logic [7:0] drop_count;
  int vectors = 0;
  int miscompares = 0;

  lag_averager #(.LOG2_AVG(2), .MAX_LAG(MAXL), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .lag_in_valid(lag_in_valid),
    .lag_in_ab(lag_in_ab), .lag_in_ac(lag_in_ac), .lag_in_bc(lag_in_bc),
    .lagsout(lagsout), .lagsout_valid(lagsout_valid),
    .timeout_pulse(timeout_pulse), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b; int c;} trip_t;
  trip_t win[$];
  int idle = 0;
  bit exp_valid = 1'b0, exp_tmo = 1'b0;
  logic [35:0] exp_lags = '0;
  int exp_drop = 0;
  trip_t cur;
  bit in_rng, take;
  int sa, sb, sc;

  function automatic int fdiv(int s);
    return (s - (((s % N) + N) % N)) / N;
  endfunction

  function automatic logic [35:0] pk(int ab, int ac, int bc);
    return {12'(bc), 12'(ac), 12'(ab)};
  endfunction

  // Model: window of accepted triples, emit floor(sum/N) when it fills
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win.delete();
      idle = 0;
      exp_valid = 1'b0;
      exp_tmo = 1'b0;
      exp_lags = '0;
      exp_drop = 0;
    end else begin
      exp_valid = 1'b0;
      exp_tmo = 1'b0;
      cur.a = $signed(lag_in_ab);
      cur.b = $signed(lag_in_ac);
      cur.c = $signed(lag_in_bc);
      in_rng = cur.a <= MAXL && cur.a >= -MAXL && cur.b <= MAXL && cur.b >= -MAXL
               && cur.c <= MAXL && cur.c >= -MAXL;
      take = lag_in_valid && !clear && (!REJ || in_rng);
      if (lag_in_valid && !clear && !take && exp_drop < 255) exp_drop++;
      if (clear) begin
        win.delete();
        idle = 0;
      end else if (take) begin
        win.push_back(cur);
        idle = 0;
        if (win.size() == N) begin
          sa = 0; sb = 0; sc = 0;
          foreach (win[i]) begin
            sa += win[i].a;
            sb += win[i].b;
            sc += win[i].c;
          end
          exp_lags = pk(fdiv(sa), fdiv(sb), fdiv(sc));
          exp_valid = 1'b1;
          win.delete();
        end
      end else if (win.size() > 0) begin
        idle++;
        if (idle > T) begin
          exp_tmo = 1'b1;
          win.delete();
          idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (lagsout_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL valid @%0t: got %b want %b", $time, lagsout_valid, exp_valid);
    end
    if (timeout_pulse !== exp_tmo) begin
      miscompares++;
      $display("FAIL timeout @%0t: got %b want %b", $time, timeout_pulse, exp_tmo);
    end
    if (lagsout !== exp_lags) begin
      miscompares++;
      $display("FAIL lagsout @%0t: got %h want %h", $time, lagsout, exp_lags);
    end
    if (drop_count !== 8'(exp_drop)) begin
      miscompares++;
      $display("FAIL drop @%0t: got %0d want %0d", $time, drop_count, exp_drop);
    end
  end

  task automatic drive(input bit v, input int ab, input int ac, input int bc, input bit c = 1'b0);
    lag_in_valid = v;
    lag_in_ab = 12'(ab);
    lag_in_ac = 12'(ac);
    lag_in_bc = 12'(bc);
    clear = c;
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(i[0], 50, 50, 50);
    chk("rst_lags", lagsout, '0);
    chk("rst_valid", 36'(lagsout_valid), '0);
    chk("rst_drop", 36'(drop_count), '0);
    reset_n = 1'b1;
    drive(1, 10, -5, 3);
    drive(1, 12, -7, 3);
    drive(1, 10, -5, 4);
    chk("pre_emit", 36'(lagsout_valid), '0);
    drive(1, 12, -7, 5);
    chk("win_valid", 36'(lagsout_valid), 36'(1));
    chk("win_avg", lagsout, pk(11, -6, 3));
    drive(1, -1, 1, 0);
    chk("hold", lagsout, pk(11, -6, 3));
    drive(1, -1, 1, 0);
    drive(1, -1, 1, 0);
    drive(1, -2, 2, 0);
    chk("floor_valid", 36'(lagsout_valid), 36'(1));
    chk("floor_avg", lagsout, pk(-2, 1, 0));
    drive(0, 0, 0, 0);
    drive(1, 4, 0, 0);
    drive(1, 41, 0, 0);
    drive(1, 8, 0, 0);
    drive(1, 4, 0, 0);
    if (REJ) begin
      chk("outl4_valid", 36'(lagsout_valid), '0);
    end else begin
      chk("outl4_valid", 36'(lagsout_valid), 36'(1));
      chk("outl4_avg", lagsout, pk(14, 0, 0));
    end
    drive(1, 4, 0, 0);
    if (REJ) begin
      chk("outl5_valid", 36'(lagsout_valid), 36'(1));
      chk("outl5_avg", lagsout, pk(5, 0, 0));
      chk("outl_drop", 36'(drop_count), 36'(1));
    end else begin
      chk("outl5_valid", 36'(lagsout_valid), '0);
      chk("outl_drop", 36'(drop_count), '0);
    end
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 1, 1);
    drive(1, 1, 1, 1);
    for (int i = 0; i < T; i++) drive(0, 0, 0, 0);
    chk("tmo_early", 36'(timeout_pulse), '0);
    drive(0, 0, 0, 0);
    chk("tmo_pulse", 36'(timeout_pulse), 36'(1));
    chk("tmo_novalid", 36'(lagsout_valid), '0);
    for (int i = 0; i < 4; i++) drive(1, 8, 8, 8);
    chk("after_tmo", lagsout, pk(8, 8, 8));
    chk("after_tmo_v", 36'(lagsout_valid), 36'(1));
    drive(1, 5, 5, 5);
    drive(1, 5, 5, 5);
    drive(1, 20, 20, 20, 1);
    for (int i = 0; i < 3; i++) drive(1, 2, 2, 2);
    chk("clr_3", 36'(lagsout_valid), '0);
    drive(1, 2, 2, 2);
    chk("clr_4_valid", 36'(lagsout_valid), 36'(1));
    chk("clr_4_avg", lagsout, pk(2, 2, 2));
    drive(1, 9, 9, 9);
    drive(1, 9, 9, 9);
    #2 reset_n = 1'b0;
    #2 chk("midrst_lags", lagsout, '0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 3, 3, 3);
    drive(1, 3, 3, 3);
    chk("midrst_2", 36'(lagsout_valid), '0);
    drive(1, 3, 3, 3);
    drive(1, 3, 3, 3);
    chk("midrst_4", lagsout, pk(3, 3, 3));
    for (int i = 0; i < 260; i++) drive(1, 100, 0, 0);
    chk("drop_sat", 36'(drop_count), REJ ? 36'(255) : '0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lag_averager.md
# lag_averager

Window-averaging stage directly upstream of the Nios lag peripheral. Takes raw time-difference-of-arrival triples (mic pairs AB, AC, BC) from the cross-correlators and averages 2^LOG2_AVG accepted triples. Rejects physically impossible lags and discards stale partial windows. Emits a packed 36-bit word plus a one-cycle valid that drive the peripheral's lagsin / lagsinvalid conduit.

## Interface
- LAG_W, 12: width of each signed lag, two's complement
- LOG2_AVG, 2: log2 of window length N; legal range 1..6
- MAX_LAG, 40: largest legal |lag|, in samples
- TIMEOUT_CYC, 1_000_000: idle cycles after which a partial window is discarded
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of the current window; takes priority over lag_in_valid
- lag_in_valid  in  1  qualifies the three lag inputs for one cycle; there is no backpressure
- lag_in_ab / lag_in_ac / lag_in_bc  in  LAG_W  signed raw lags
- lagsout  out  3*LAG_W  packed averages: [LAG_W-1:0]=AB, [2*LAG_W-1:LAG_W]=AC, [3*LAG_W-1:2*LAG_W]=BC
- lagsout_valid  out  1  one-cycle pulse when lagsout updates
- timeout_pulse  out  1  one-cycle pulse when a partial window is discarded by timeout
- drop_count  out  8  saturating count of rejected triples

## Operation
- **Reset values:** all outputs 0, accumulators 0, count 0, state IDLE.
- **Accumulators:** three signed accumulators, each LAG_W+LOG2_AVG bits, sign-extended on add; overflow is impossible by construction.
- **Accepted triple:** lag_in_valid=1, clear=0, and the triple passes the outlier check (see Configuration).
- **Averaging:** average = accumulator >>> LOG2_AVG, i.e. arithmetic shift with floor toward −∞. The result is truncated to LAG_W bits; this is lossless because |average| ≤ MAX_LAG.
- **IDLE:** count=0, accumulators=0.
  - Accepted triple → load accumulators with it, count=1, go to ACCUM.
- **ACCUM:**
  - Accepted triple → add it, count+1, reset the idle counter.
  - The add that makes count=N → register the averages into lagsout, assert lagsout_valid the next cycle, clear accumulators and count, go to EMIT.
  - Idle counter reaches TIMEOUT_CYC with no accepted triple → discard the window, pulse timeout_pulse, go to IDLE.
- **EMIT:** lasts one cycle, during which lagsout_valid=1.
  - An accepted triple in this cycle starts the next window (count=1, go to ACCUM); otherwise go to IDLE. There is no dead cycle between windows.
- **clear:** from any state, zero accumulators, count and idle counter and go to IDLE. lagsout keeps its value. A pending EMIT pulse still completes.
- **Hold behaviour:** lagsout holds its last value between emits.
- **Mid-window reset:** drops the partial window; no output.

## Timing
- lagsout and lagsout_valid change one clock after the edge that samples the Nth accepted triple.
- Sustained throughput: one triple per cycle; the emit period is exactly N cycles.
- timeout_pulse asserts TIMEOUT_CYC+1 edges after the last accepted triple.
- drop_count updates one cycle after the rejected input and saturates at 255.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- **LAG_AVG_OUTLIER_REJECT_EN defined:** a triple with any |lag| > MAX_LAG is not accepted.
  - It does not reset the idle counter.
  - drop_count increments.
- **LAG_AVG_OUTLIER_REJECT_EN undefined:** every valid triple is accepted, and drop_count is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package lag_pkg holds:
  - LAG_W, the lag_triple_t struct {ab, ac, bc}, and the state enum {IDLE, ACCUM, EMIT};
  - the pack/unpack functions for the 36-bit conduit layout, reused by the peripheral.
- One sub-module, lag_accum_lane: a single signed accumulator with load, add, clear and shift-out. It is instantiated three times.
- The FSM, idle counter, outlier check and drop counter live in the top level.

## Test plan
- **Reset:** hold reset_n=0 with valid toggling → lagsout=0, lagsout_valid=0, drop_count=0. After release, nothing is emitted before the 4th accepted triple.
- **Window average (LOG2_AVG=2):** triples (10,−5,3), (12,−7,3), (10,−5,4), (12,−7,5) on back-to-back cycles → one cycle later lagsout = (11,−6,3) with one valid pulse. A 5th triple the same cycle as the pulse starts the next window.
- **Floor rounding:** AB lags −1,−1,−1,−2 → −2. AB lags 1,1,1,2 → 1.
- **Outlier rejection:** the 2nd of five triples has ab=41.
  - With the macro: drop_count=1, and the emitted average covers triples 1, 3, 4, 5.
  - Without the macro: the emit follows the 4th triple and includes 41.
- **Timeout:** 2 triples, then TIMEOUT_CYC+1 idle cycles → timeout_pulse, no valid. Then 4 triples of (8,8,8) → output (8,8,8).
- **clear:** clear asserted together with the 3rd triple → that triple is ignored. Exactly 4 further triples are needed before the next emit.
